obi_demux_mgr: RTL and testbench
================================

OBI_DEMUX_MGR -- requirements
Module: obi_demux_mgr

Interface
REQ-001 SHALL have parameter NUM_SBR, default 2: number of OBI subordinates, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width; BE_W = DATA_W/8.
REQ-004 SHALL have parameter MAX_OUTST, default 4: maximum in-flight transactions.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have manager-side inputs req_i (1), we_i (1), be_i (BE_W), addr_i (ADDR_W), wdata_i (DATA_W).
REQ-008 SHALL have manager-side outputs gnt_o (1), rvalid_o (1), rdata_o (DATA_W), err_o (1), err_cnt_o (8).
REQ-009 SHALL have per-subordinate outputs sbr_req_o [NUM_SBR], sbr_we_o [NUM_SBR], sbr_be_o [NUM_SBR][BE_W], sbr_addr_o [NUM_SBR][ADDR_W], sbr_wdata_o [NUM_SBR][DATA_W].
REQ-010 SHALL have per-subordinate inputs sbr_gnt_i [NUM_SBR], sbr_rvalid_i [NUM_SBR], sbr_rdata_i [NUM_SBR][DATA_W], sbr_err_i [NUM_SBR].

Function
REQ-011 SHALL decode target sel = addr_i[ADDR_W-1 -: SEL_W], with SEL_W = max(1, clog2(NUM_SBR)); sel >= NUM_SBR is a decode error.
REQ-012 SHALL drive sbr_req_o[sel] = req_i & ~stall combinationally; all other sbr_req_o are 0; we/be/addr/wdata are broadcast to all subordinates.
REQ-013 SHALL drive gnt_o = sbr_gnt_i[sel] & ~stall for valid sel, and gnt_o = ~stall for a decode error.
REQ-014 SHALL assert stall when outst_cnt == MAX_OUTST, or when outst_cnt != 0 and sel != cur_tgt (response-order protection).
REQ-015 SHALL register cur_tgt <= sel on every accepted handshake (req_i & gnt_o); decode errors use the internal target index NUM_SBR.
REQ-016 SHALL increment outst_cnt on handshake, decrement on rvalid_o, and leave it unchanged when both occur in the same cycle.
REQ-017 SHALL route rvalid_o, rdata_o and err_o from sbr_*_i[cur_tgt].
REQ-018 SHALL answer a decode error exactly one cycle after the handshake with rvalid_o=1, err_o=1, rdata_o=0; no subordinate sees the request.
REQ-019 SHALL ignore sbr_rvalid_i from any non-current target and SHALL NOT let such a response change outst_cnt.
REQ-020 SHALL keep rdata_o at 0 when rvalid_o=0.

Reset
REQ-021 SHALL, while rst_ni=0, force outst_cnt=0, cur_tgt=0, the error-response flag=0, rvalid_o=0, err_o=0, rdata_o=0, err_cnt_o=0 and all sbr_req_o=0.
REQ-022 SHALL discard all in-flight transactions when reset asserts mid-operation; responses arriving after reset release are ignored because outst_cnt=0.

Configuration
REQ-023 SHALL, when macro OBI_DEMUX_ERR_CNT_EN is defined, increment err_cnt_o on each rvalid_o & err_o, saturating at 8'hFF.
REQ-024 SHALL, without OBI_DEMUX_ERR_CNT_EN, tie err_cnt_o to 8'h00 and implement no counter flops.

Structure
REQ-025 SHALL place the OBI request/response struct typedefs, the SEL_W function and the error-counter width constant in the shared package obi_pkg.
REQ-026 SHALL implement the decode-error responder as sub-module obi_err_sbr (always grants; one-cycle error response).

Verification (NUM_SBR=3, MAX_OUTST=2, SEL_W=2, macro defined)
REQ-027 SHALL verify: a read to 0x0000_000C, with sbr0 returning 0x0000_3333 one cycle after grant -> only sbr_req_o[0] is asserted, and rdata_o=0x0000_3333 with err_o=0.
REQ-028 SHALL verify: a write of 0x1337_C0DE with be 4'hF to 0x4000_0004 -> sbr1 sees we=1, addr=0x4000_0004, wdata=0x1337_C0DE; rvalid_o=1, err_o=0.
REQ-029 SHALL verify: a read to 0xC000_0000 -> no sbr_req_o asserted, gnt_o=1, next cycle rvalid_o=1, err_o=1, rdata_o=0, and err_cnt_o goes 0->1.
REQ-030 SHALL verify: two back-to-back requests to sbr0 with responses held off -> a third request gets gnt_o=0 until the first rvalid_o.
REQ-031 SHALL verify: an outstanding sbr0 read followed by a request to 0x4000_0000 -> gnt_o=0 and sbr_req_o[1]=0 until the sbr0 response completes.
REQ-032 SHALL verify: 260 decode-error reads -> err_cnt_o=8'hFF; then rst_ni pulsed low -> err_cnt_o=0 and outst_cnt=0 immediately.

Source files
------------

// File: rtl/obi_pkg.sv
// obi_pkg: shared OBI typedefs, target-select width helper and error-counter width.
// No ports; imported by obi_err_sbr and obi_demux_mgr.
package obi_pkg;
    localparam int ERR_CNT_W  = 8;
    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;

    typedef struct packed {
        logic                    req;
        logic                    we;
        logic [OBI_DATA_W/8-1:0] be;
        logic [OBI_ADDR_W-1:0]   addr;
        logic [OBI_DATA_W-1:0]   wdata;
    } obi_req_t;

    typedef struct packed {
        logic                  gnt;
        logic                  rvalid;
        logic [OBI_DATA_W-1:0] rdata;
        logic                  err;
    } obi_rsp_t;

    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/obi_err_sbr.sv
// obi_err_sbr: decode-error subordinate, always grants and answers one cycle later with err.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i request;
//        gnt_o grant; rvalid_o/rdata_o/err_o response (rdata always 0).
module obi_err_sbr import obi_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);
    logic rvalid_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) rvalid_q <= 1'b0;
        else         rvalid_q <= req_i;

    assign gnt_o    = 1'b1;
    assign rvalid_o = rvalid_q;
    assign err_o    = rvalid_q;
    assign rdata_o  = '0;
endmodule

// File: rtl/obi_demux_mgr.sv
// obi_demux_mgr: OBI 1-to-NUM_SBR address demultiplexer with in-order response protection.
// Ports: clk_i/rst_ni clock and async active-low reset;
//        req_i/we_i/be_i/addr_i/wdata_i manager request; gnt_o/rvalid_o/rdata_o/err_o response;
//        err_cnt_o error-response count (live only with OBI_DEMUX_ERR_CNT_EN defined);
//        sbr_*_o per-subordinate request (we/be/addr/wdata broadcast); sbr_*_i per-subordinate response.
// Target is addr_i MSBs; unmapped targets go to an internal error subordinate at index NUM_SBR.
module obi_demux_mgr import obi_pkg::*; #(
    parameter int NUM_SBR   = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4,
    parameter int BE_W      = DATA_W / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [BE_W-1:0]      be_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [DATA_W-1:0]    rdata_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [NUM_SBR-1:0]   sbr_req_o,
    output logic [NUM_SBR-1:0]   sbr_we_o,
    output logic [BE_W-1:0]      sbr_be_o    [NUM_SBR],
    output logic [ADDR_W-1:0]    sbr_addr_o  [NUM_SBR],
    output logic [DATA_W-1:0]    sbr_wdata_o [NUM_SBR],
    input  logic [NUM_SBR-1:0]   sbr_gnt_i,
    input  logic [NUM_SBR-1:0]   sbr_rvalid_i,
    input  logic [DATA_W-1:0]    sbr_rdata_i [NUM_SBR],
    input  logic [NUM_SBR-1:0]   sbr_err_i
);
    localparam int SEL_W = sel_w(NUM_SBR);
    localparam int TGT_W = $clog2(NUM_SBR + 1);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [SEL_W-1:0]  sel;
    logic              dec_err;
    logic [TGT_W-1:0]  tgt, cur_tgt_q;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic              stall, hs;
    logic              err_gnt, err_rvalid, err_err;
    logic [DATA_W-1:0] err_rdata;
    logic [NUM_SBR:0]  gnt_all, rvalid_all, err_all;
    logic [DATA_W-1:0] rdata_all [NUM_SBR+1];

    assign sel     = addr_i[ADDR_W-1 -: SEL_W];
    assign dec_err = int'(sel) >= NUM_SBR;
    assign tgt     = dec_err ? TGT_W'(NUM_SBR) : TGT_W'(sel);
    // Switching targets only when idle keeps responses in request order.
    assign stall   = (outst_q == CNT_W'(MAX_OUTST)) | ((outst_q != '0) & (tgt != cur_tgt_q));

    obi_err_sbr #(.DATA_W(DATA_W)) u_err_sbr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i & dec_err & ~stall),
        .gnt_o    (err_gnt),
        .rvalid_o (err_rvalid),
        .rdata_o  (err_rdata),
        .err_o    (err_err)
    );

    for (genvar i = 0; i < NUM_SBR; i++) begin : g_sbr
        assign sbr_req_o[i]   = rst_ni & req_i & ~stall & (tgt == TGT_W'(i));
        assign sbr_we_o[i]    = we_i;
        assign sbr_be_o[i]    = be_i;
        assign sbr_addr_o[i]  = addr_i;
        assign sbr_wdata_o[i] = wdata_i;
        assign rdata_all[i]   = sbr_rdata_i[i];
    end
    assign rdata_all[NUM_SBR] = err_rdata;
    assign gnt_all            = {err_gnt, sbr_gnt_i};
    assign rvalid_all         = {err_rvalid, sbr_rvalid_i};
    assign err_all            = {err_err, sbr_err_i};

    assign gnt_o = gnt_all[tgt] & ~stall;
    assign hs    = req_i & gnt_o;
    // Gating with a non-zero count drops stray responses from idle or reset-discarded targets.
    assign rvalid_o = rvalid_all[cur_tgt_q] & (outst_q != '0);
    assign err_o    = rvalid_o & err_all[cur_tgt_q];
    assign rdata_o  = rvalid_o ? rdata_all[cur_tgt_q] : '0;
    assign outst_d  = outst_q + CNT_W'(hs) - CNT_W'(rvalid_o);

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            outst_q   <= '0;
            cur_tgt_q <= '0;
        end else begin
            outst_q   <= outst_d;
            cur_tgt_q <= hs ? tgt : cur_tgt_q;
        end

`ifdef OBI_DEMUX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni)                          err_cnt_q <= '0;
        else if (err_o & ~(&err_cnt_q))       err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_obi_demux_mgr.sv
// tb_obi_demux_mgr: directed and randomized checks of obi_demux_mgr (NUM_SBR=3, MAX_OUTST=2).
module tb_obi_demux_mgr;
    localparam int NS = 3, AW = 32, DW = 32, BW = 4, MO = 2;
`ifdef OBI_DEMUX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int          tgt;
        logic [31:0] data;
        bit          err;
        int          due;
    } resp_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          req_i, we_i;
    logic [BW-1:0] be_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic          gnt_o, rvalid_o, err_o;
    logic [DW-1:0] rdata_o;
    logic [7:0]    err_cnt_o;
    logic [NS-1:0] sbr_req_o, sbr_we_o;
    logic [BW-1:0] sbr_be_o [NS];
    logic [AW-1:0] sbr_addr_o [NS];
    logic [DW-1:0] sbr_wdata_o [NS];
    logic [NS-1:0] sbr_gnt_i, sbr_rvalid_i, sbr_err_i;
    logic [DW-1:0] sbr_rdata_i [NS];

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    obi_demux_mgr #(.NUM_SBR(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_i(req_i), .we_i(we_i), .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .err_cnt_o(err_cnt_o),
        .sbr_req_o(sbr_req_o), .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o),
        .sbr_addr_o(sbr_addr_o), .sbr_wdata_o(sbr_wdata_o),
        .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i),
        .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        req_i = 0; we_i = 0; be_i = '0; addr_i = '0; wdata_i = '0;
        sbr_gnt_i = '1; sbr_rvalid_i = '0; sbr_err_i = '0;
        for (int s = 0; s < NS; s++) sbr_rdata_i[s] = '0;
    endtask

    task automatic model_err(input bit hit);
        if (hit && CNT_EN && exp_cnt < 255) exp_cnt++;
    endtask

    task automatic test_reset();
        idle();
        rst_ni = 0;
        req_i = 1; addr_i = 32'h0000_0000;
        repeat (2) @(negedge clk_i);
        checks++;
        if (sbr_req_o !== 3'b000) begin errors++; $display("FAIL reset_req: sbr_req_o=%b want 000", sbr_req_o); end
        checks++;
        if ({rvalid_o, err_o, rdata_o, err_cnt_o} !== '0)
            begin errors++; $display("FAIL reset_rsp: rvalid=%b err=%b rdata=%h cnt=%h want 0", rvalid_o, err_o, rdata_o, err_cnt_o); end
        req_i = 0;
        rst_ni = 1;
        @(negedge clk_i);
        checks++;
        if ({rvalid_o, sbr_req_o, err_cnt_o} !== '0)
            begin errors++; $display("FAIL post_reset: rvalid=%b req=%b cnt=%h want 0", rvalid_o, sbr_req_o, err_cnt_o); end
    endtask

    task automatic test_read_sbr0();
        @(negedge clk_i);
        idle(); req_i = 1; addr_i = 32'h0000_000C; be_i = 4'hF;
        #1;
        checks++;
        if ({sbr_req_o, gnt_o} !== 4'b0011) begin errors++; $display("FAIL rd0_req: req=%b gnt=%b want 001/1", sbr_req_o, gnt_o); end
        @(negedge clk_i);
        req_i = 0; sbr_rvalid_i[0] = 1; sbr_rdata_i[0] = 32'h0000_3333; sbr_rdata_i[1] = 32'hBAD0_0001;
        #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h0000_3333})
            begin errors++; $display("FAIL rd0_rsp: rvalid=%b err=%b rdata=%h want 1/0/00003333", rvalid_o, err_o, rdata_o); end
        @(negedge clk_i);
        idle();
        #1;
        checks++;
        if ({rvalid_o, rdata_o} !== '0) begin errors++; $display("FAIL rd0_idle: rvalid=%b rdata=%h want 0/0", rvalid_o, rdata_o); end
    endtask

    task automatic test_write_sbr1();
        @(negedge clk_i);
        idle(); req_i = 1; we_i = 1; be_i = 4'hF; addr_i = 32'h4000_0004; wdata_i = 32'h1337_C0DE;
        #1;
        checks++;
        if ({sbr_req_o, gnt_o, sbr_we_o[1], sbr_be_o[1], sbr_addr_o[1], sbr_wdata_o[1]} !==
            {3'b010, 1'b1, 1'b1, 4'hF, 32'h4000_0004, 32'h1337_C0DE})
            begin errors++; $display("FAIL wr1_req: req=%b gnt=%b we=%b be=%h addr=%h wdata=%h", sbr_req_o, gnt_o, sbr_we_o[1], sbr_be_o[1], sbr_addr_o[1], sbr_wdata_o[1]); end
        @(negedge clk_i);
        idle(); sbr_rvalid_i[1] = 1;
        #1;
        checks++;
        if ({rvalid_o, err_o} !== 2'b10) begin errors++; $display("FAIL wr1_rsp: rvalid=%b err=%b want 1/0", rvalid_o, err_o); end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_decode_err();
        @(negedge clk_i);
        idle(); req_i = 1; addr_i = 32'hC000_0000;
        #1;
        checks++;
        if (err_cnt_o !== 8'(exp_cnt)) begin errors++; $display("FAIL derr_cnt0: cnt=%h want %h", err_cnt_o, 8'(exp_cnt)); end
        checks++;
        if ({sbr_req_o, gnt_o} !== 4'b0001) begin errors++; $display("FAIL derr_req: req=%b gnt=%b want 000/1", sbr_req_o, gnt_o); end
        @(negedge clk_i);
        idle(); sbr_rvalid_i = 3'b101; sbr_rdata_i[0] = 32'hFFFF_FFFF; sbr_rdata_i[2] = 32'h5555_5555;
        #1;
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== {2'b11, 32'h0})
            begin errors++; $display("FAIL derr_rsp: rvalid=%b err=%b rdata=%h want 1/1/0", rvalid_o, err_o, rdata_o); end
        model_err(1);
        @(negedge clk_i);
        idle();
        #1;
        checks++;
        if ({rvalid_o, err_cnt_o} !== {1'b0, 8'(exp_cnt)})
            begin errors++; $display("FAIL derr_cnt1: rvalid=%b cnt=%h want 0/%h", rvalid_o, err_cnt_o, 8'(exp_cnt)); end
    endtask

    task automatic test_outst_limit();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            idle(); req_i = 1; addr_i = 32'h0000_0010 + 32'(4 * k);
            #1;
            checks++;
            if (gnt_o !== (k < 2)) begin errors++; $display("FAIL limit_gnt%0d: gnt=%b want %b", k, gnt_o, k < 2); end
            if (k >= 2) begin
                checks++;
                if (sbr_req_o !== 3'b000) begin errors++; $display("FAIL limit_req%0d: req=%b want 000", k, sbr_req_o); end
            end
        end
        @(negedge clk_i);
        sbr_rvalid_i[0] = 1; sbr_rdata_i[0] = 32'hA1;
        #1;
        checks++;
        if ({rvalid_o, rdata_o, gnt_o} !== {1'b1, 32'hA1, 1'b0})
            begin errors++; $display("FAIL limit_rsp1: rvalid=%b rdata=%h gnt=%b want 1/a1/0", rvalid_o, rdata_o, gnt_o); end
        @(negedge clk_i);
        sbr_rvalid_i[0] = 0;
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin errors++; $display("FAIL limit_regnt: gnt=%b want 1", gnt_o); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            idle(); sbr_rvalid_i[0] = 1; sbr_rdata_i[0] = 32'hA2 + 32'(k);
            #1;
            checks++;
            if ({rvalid_o, rdata_o} !== {1'b1, 32'hA2 + 32'(k)})
                begin errors++; $display("FAIL limit_drain%0d: rvalid=%b rdata=%h want 1/%h", k, rvalid_o, rdata_o, 32'hA2 + 32'(k)); end
        end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_order_protect();
        @(negedge clk_i);
        idle(); req_i = 1; addr_i = 32'h0000_0020;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            idle(); req_i = 1; addr_i = 32'h4000_0000;
            if (k == 2) begin sbr_rvalid_i[0] = 1; sbr_rdata_i[0] = 32'hB0; end
            #1;
            checks++;
            if ({gnt_o, sbr_req_o} !== 4'b0000) begin errors++; $display("FAIL order_hold%0d: gnt=%b req=%b want 0/000", k, gnt_o, sbr_req_o); end
        end
        @(negedge clk_i);
        sbr_rvalid_i = '0;
        #1;
        checks++;
        if ({gnt_o, sbr_req_o} !== 4'b1010) begin errors++; $display("FAIL order_go: gnt=%b req=%b want 1/010", gnt_o, sbr_req_o); end
        @(negedge clk_i);
        idle(); sbr_rvalid_i[1] = 1; sbr_rdata_i[1] = 32'hB1;
        #1;
        checks++;
        if ({rvalid_o, rdata_o} !== {1'b1, 32'hB1}) begin errors++; $display("FAIL order_rsp: rvalid=%b rdata=%h want 1/b1", rvalid_o, rdata_o); end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_random(input int ncyc);
        resp_t q[$];
        resp_t r;
        int    n = 0, cur = 0, last_due = 0, t, lat;
        bit    issue, deliver, stall, exp_gnt, hs;
        logic [NS-1:0] exp_req;
        logic [DW-1:0] exp_rdata;
        for (int c = 0; c < ncyc + 20; c++) begin
            @(negedge clk_i);
            issue = (c < ncyc) && ($urandom_range(0, 3) != 0);
            t = $urandom_range(0, 3);
            req_i = issue; we_i = 1'($urandom); be_i = 4'($urandom); wdata_i = $urandom;
            addr_i = {t[1:0], 30'($urandom)};
            sbr_gnt_i = 3'($urandom); sbr_rvalid_i = '0; sbr_err_i = 3'($urandom);
            for (int s = 0; s < NS; s++) sbr_rdata_i[s] = $urandom;
            deliver = (q.size() > 0) && (q[0].due <= c);
            if (deliver && q[0].tgt < NS) begin
                sbr_rvalid_i[q[0].tgt] = 1; sbr_rdata_i[q[0].tgt] = q[0].data; sbr_err_i[q[0].tgt] = q[0].err;
            end
            for (int s = 0; s < NS; s++)
                if ((n == 0 || s != cur) && $urandom_range(0, 7) == 0) sbr_rvalid_i[s] = 1;
            #1;
            stall = (n == MO) || (n > 0 && t != cur);
            exp_gnt = !stall && (t == NS || sbr_gnt_i[t]);
            exp_req = (issue && !stall && t < NS) ? 3'(1 << t) : 3'b000;
            exp_rdata = deliver ? q[0].data : '0;
            checks++;
            if ({gnt_o, sbr_req_o} !== {exp_gnt, exp_req})
                begin errors++; $display("FAIL rnd_gnt c%0d: gnt=%b req=%b want %b/%b", c, gnt_o, sbr_req_o, exp_gnt, exp_req); end
            checks++;
            if ({rvalid_o, err_o, rdata_o} !== {deliver, deliver && q[0].err, exp_rdata})
                begin errors++; $display("FAIL rnd_rsp c%0d: rvalid=%b err=%b rdata=%h want %b/%b/%h", c, rvalid_o, err_o, rdata_o, deliver, deliver && q[0].err, exp_rdata); end
            checks++;
            if (err_cnt_o !== 8'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt c%0d: cnt=%h want %h", c, err_cnt_o, 8'(exp_cnt)); end
            if (t < NS) begin
                checks++;
                if ({sbr_we_o[t], sbr_be_o[t], sbr_addr_o[t], sbr_wdata_o[t]} !== {we_i, be_i, addr_i, wdata_i})
                    begin errors++; $display("FAIL rnd_bcast c%0d: sbr%0d we=%b be=%h addr=%h wdata=%h", c, t, sbr_we_o[t], sbr_be_o[t], sbr_addr_o[t], sbr_wdata_o[t]); end
            end
            hs = issue && exp_gnt;
            if (deliver) begin model_err(q[0].err); void'(q.pop_front()); end
            if (hs) begin
                lat = $urandom_range(1, 3);
                r.tgt = t;
                r.err = (t == NS) ? 1'b1 : 1'($urandom);
                r.data = (t == NS) ? 32'h0 : $urandom;
                r.due = (t == NS) ? c + 1 : ((c + lat > last_due + 1) ? c + lat : last_due + 1);
                last_due = r.due;
                cur = t;
                q.push_back(r);
            end
            n = q.size();
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d responses left want 0", q.size()); end
        @(negedge clk_i);
        idle();
    endtask

    task automatic test_err_sat_reset();
        @(negedge clk_i);
        idle(); req_i = 1; addr_i = 32'hC000_0000;
        repeat (260) begin
            @(negedge clk_i);
            model_err(1);
        end
        req_i = 0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (err_cnt_o !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_cnt: cnt=%h want %h", err_cnt_o, 8'(exp_cnt)); end
        checks++;
        if (err_cnt_o !== (CNT_EN ? 8'hFF : 8'h00)) begin errors++; $display("FAIL sat_value: cnt=%h want %h", err_cnt_o, CNT_EN ? 8'hFF : 8'h00); end
        @(negedge clk_i);
        idle(); req_i = 1; addr_i = 32'h0000_0040;
        @(negedge clk_i);
        idle();
        #2 rst_ni = 0;
        #1;
        exp_cnt = 0;
        checks++;
        if ({err_cnt_o, rvalid_o, sbr_req_o} !== '0)
            begin errors++; $display("FAIL rst_mid: cnt=%h rvalid=%b req=%b want 0", err_cnt_o, rvalid_o, sbr_req_o); end
        @(negedge clk_i);
        rst_ni = 1;
        @(negedge clk_i);
        idle(); sbr_rvalid_i[0] = 1; sbr_rdata_i[0] = 32'hDEAD_0000; req_i = 1; addr_i = 32'h4000_0008;
        #1;
        checks++;
        if ({rvalid_o, gnt_o, sbr_req_o} !== {1'b0, 1'b1, 3'b010})
            begin errors++; $display("FAIL rst_stale: rvalid=%b gnt=%b req=%b want 0/1/010", rvalid_o, gnt_o, sbr_req_o); end
        @(negedge clk_i);
        idle(); sbr_rvalid_i[1] = 1; sbr_rdata_i[1] = 32'hC1;
        #1;
        checks++;
        if ({rvalid_o, rdata_o} !== {1'b1, 32'hC1}) begin errors++; $display("FAIL rst_resume: rvalid=%b rdata=%h want 1/c1", rvalid_o, rdata_o); end
        @(negedge clk_i);
        idle();
    endtask

    initial begin
        test_reset();
        test_read_sbr0();
        test_write_sbr1();
        test_decode_err();
        test_outst_limit();
        test_order_protect();
        test_random(600);
        test_err_sat_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
